// File: rtl/sw_pe_gen_if.sv
// Bundle of every per-cell signal exchanged between a Smith-Waterman PE and
// its neighbours/controller. The slave modport is the PE side, the master
// modport is whoever feeds it. tb_dir exists only when SW_PE_TRACEBACK_EN
// is defined.
interface sw_pe_gen_if #(
  parameter int SCORE_W = 16,
  parameter int SYM_W   = 2,
  parameter int POS_W   = 12
);
  logic                      valid_in;
  logic                      valid_out;
  logic                      new_line_in;
  logic                      new_line_out;
  logic        [SYM_W-1:0]   s_sym;
  logic        [SYM_W-1:0]   t_in;
  logic        [SYM_W-1:0]   t_out;
  logic signed [SCORE_W-1:0] v_in;
  logic signed [SCORE_W-1:0] v_in_alpha;
  logic signed [SCORE_W-1:0] f_in;
  logic signed [SCORE_W-1:0] v_out;
  logic signed [SCORE_W-1:0] v_out_alpha;
  logic signed [SCORE_W-1:0] f_out;
  logic signed [SCORE_W-1:0] minus_alpha;
  logic signed [SCORE_W-1:0] minus_beta;
  logic signed [SCORE_W-1:0] match;
  logic signed [SCORE_W-1:0] mismatch;
  logic                      local_mode;
  logic signed [SCORE_W-1:0] best_score;
  logic        [POS_W-1:0]   best_pos;
`ifdef SW_PE_TRACEBACK_EN
  logic        [1:0]         tb_dir;
`endif

  modport master (
    output valid_in, new_line_in, s_sym, t_in, v_in, v_in_alpha, f_in,
           minus_alpha, minus_beta, match, mismatch, local_mode,
    input  valid_out, new_line_out, t_out, v_out, v_out_alpha, f_out,
           best_score, best_pos
`ifdef SW_PE_TRACEBACK_EN
    , input tb_dir
`endif
  );

  modport slave (
    input  valid_in, new_line_in, s_sym, t_in, v_in, v_in_alpha, f_in,
           minus_alpha, minus_beta, match, mismatch, local_mode,
    output valid_out, new_line_out, t_out, v_out, v_out_alpha, f_out,
           best_score, best_pos
`ifdef SW_PE_TRACEBACK_EN
    , output tb_dir
`endif
  );
endinterface

// File: rtl/sw_pe_gen.sv
// Parametrised Smith-Waterman processing element with affine gaps,
// saturating signed arithmetic, local/global mode, valid/stall qualifier
// and per-line best-score tracking. One cell per valid cycle, 1-cycle
// latency, all outputs registered.
// Optional macro: SW_PE_TRACEBACK_EN adds a registered tb_dir output
// (01 diag, 10 up/E, 11 left/F, 00 zero clamp).
module sw_pe_gen #(
  parameter int SCORE_W = 16,
  parameter int SYM_W   = 2,
  parameter int POS_W   = 12
) (
  input logic         clk,
  input logic         rst,
  sw_pe_gen_if.slave  bus
);

  localparam logic signed [SCORE_W-1:0] S_MAX  = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SCORE_W-1:0] S_MIN  = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] S_ZERO = '0;
  localparam logic        [POS_W-1:0]   P_MAX  = {POS_W{1'b1}};

  // Signed add that clamps to the representable range instead of wrapping.
  function automatic logic signed [SCORE_W-1:0] sat_add(
    input logic signed [SCORE_W-1:0] a,
    input logic signed [SCORE_W-1:0] b
  );
    logic [SCORE_W:0] s;
    s = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
    if (s[SCORE_W] != s[SCORE_W-1]) sat_add = s[SCORE_W] ? S_MIN : S_MAX;
    else                            sat_add = s[SCORE_W-1:0];
  endfunction

  function automatic logic signed [SCORE_W-1:0] smax(
    input logic signed [SCORE_W-1:0] a,
    input logic signed [SCORE_W-1:0] b
  );
    smax = (a > b) ? a : b;
  endfunction

  // State registers
  logic                      vld_q, nl_q;
  logic        [SYM_W-1:0]   t_q;
  logic signed [SCORE_W-1:0] diag_q, e_q, v_q, va_q, f_q, best_q;
  logic        [POS_W-1:0]   pos_q, bpos_q;

  // Next-state values for the cell currently on the inputs
  logic signed [SCORE_W-1:0] lut_d, diag_d, e_d, f_d, v_d, va_d, best_d;
  logic signed [SCORE_W-1:0] vd_d, pe_d, vdiag_d;
  logic        [POS_W-1:0]   pos_d, bpos_d;

`ifdef SW_PE_TRACEBACK_EN
  logic [1:0] dir_q, dir_d;
`endif

  // DP recurrence for one cell; E uses the current v_out_alpha register.
  always_comb begin
    lut_d   = (bus.s_sym == bus.t_in) ? bus.match : bus.mismatch;
    vd_d    = bus.new_line_in ? S_ZERO : diag_q;
    pe_d    = bus.new_line_in ? S_ZERO : e_q;
    diag_d  = sat_add(vd_d, lut_d);
    e_d     = smax(sat_add(pe_d, bus.minus_beta), va_q);
    f_d     = smax(bus.v_in_alpha, sat_add(bus.f_in, bus.minus_beta));
    vdiag_d = bus.local_mode ? smax(diag_d, S_ZERO) : diag_d;
    v_d     = smax(smax(e_d, f_d), vdiag_d);
    va_d    = sat_add(v_d, bus.minus_alpha);
  end

  // Cell position and best-so-far; ties keep the earlier position.
  always_comb begin
    pos_d  = bus.new_line_in ? '0 : ((pos_q == P_MAX) ? pos_q : pos_q + POS_W'(1));
    best_d = best_q;
    bpos_d = bpos_q;
    if (bus.new_line_in) begin
      best_d = v_d;
      bpos_d = '0;
    end else if (v_d > best_q) begin
      best_d = v_d;
      bpos_d = pos_d;
    end
  end

`ifdef SW_PE_TRACEBACK_EN
  // Traceback source: zero clamp first, then diag, E, F in that order.
  always_comb begin
    if (bus.local_mode && (v_d == S_ZERO) && (diag_d <= S_ZERO)) dir_d = 2'b00;
    else if (diag_d == v_d)                                      dir_d = 2'b01;
    else if (e_d == v_d)                                         dir_d = 2'b10;
    else                                                         dir_d = 2'b11;
  end
`endif

  // Register the cell on valid cycles; hold everything during a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      nl_q   <= 1'b0;
      t_q    <= '0;
      diag_q <= '0;
      e_q    <= '0;
      v_q    <= '0;
      va_q   <= '0;
      f_q    <= '0;
      best_q <= '0;
      pos_q  <= '0;
      bpos_q <= '0;
`ifdef SW_PE_TRACEBACK_EN
      dir_q  <= 2'b00;
`endif
    end else begin
      vld_q <= bus.valid_in;
      if (bus.valid_in) begin
        nl_q   <= bus.new_line_in;
        t_q    <= bus.t_in;
        diag_q <= bus.v_in;
        e_q    <= e_d;
        v_q    <= v_d;
        va_q   <= va_d;
        f_q    <= f_d;
        best_q <= best_d;
        pos_q  <= pos_d;
        bpos_q <= bpos_d;
`ifdef SW_PE_TRACEBACK_EN
        dir_q  <= dir_d;
`endif
      end
    end
  end

  assign bus.valid_out    = vld_q;
  assign bus.new_line_out = nl_q;
  assign bus.t_out        = t_q;
  assign bus.v_out        = v_q;
  assign bus.v_out_alpha  = va_q;
  assign bus.f_out        = f_q;
  assign bus.best_score   = best_q;
  assign bus.best_pos     = bpos_q;
`ifdef SW_PE_TRACEBACK_EN
  assign bus.tb_dir       = dir_q;
`endif

endmodule

// File: tb/tb_sw_pe_gen.sv
// Self-checking bench for sw_pe_gen: directed scenarios plus randomized
// cells compared against an integer reference of the DP cell rules.
module tb_sw_pe_gen;
  localparam int SW   = 8;
  localparam int YW   = 2;
  localparam int PW   = 4;
  localparam int SMAX = 127;
  localparam int SMIN = -128;
  localparam int PMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sw_pe_gen_if #(.SCORE_W(SW), .SYM_W(YW), .POS_W(PW)) bus();
  sw_pe_gen #(.SCORE_W(SW), .SYM_W(YW), .POS_W(PW)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passed = 0;

  // scoring parameters currently applied
  int p_match = 2, p_mis = -1, p_ma = -3, p_mb = -1, p_local = 1;

  // reference state (what the outputs should show)
  int m_diag, m_e, m_v, m_va, m_f, m_pos, m_best, m_bpos, m_dir, m_vo, m_nl, m_t;

  function automatic int clampi(int x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  function automatic int maxi(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_clear();
    m_diag = 0; m_e = 0; m_v = 0; m_va = 0; m_f = 0; m_pos = 0;
    m_best = 0; m_bpos = 0; m_dir = 0; m_vo = 0; m_nl = 0; m_t = 0;
  endtask

  task automatic set_defaults();
    p_match = 2; p_mis = -1; p_ma = -3; p_mb = -1; p_local = 1;
  endtask

  // Drive one cycle of inputs, advance the reference, sample after the edge.
  task automatic step(input bit vld, input bit nl, input int s, input int t,
                      input int vin, input int vina, input int fin);
    int lut, diag, e, f, v, npos;
    bus.valid_in    = vld;
    bus.new_line_in = nl;
    bus.s_sym       = YW'(s);
    bus.t_in        = YW'(t);
    bus.v_in        = SW'(vin);
    bus.v_in_alpha  = SW'(vina);
    bus.f_in        = SW'(fin);
    bus.match       = SW'(p_match);
    bus.mismatch    = SW'(p_mis);
    bus.minus_alpha = SW'(p_ma);
    bus.minus_beta  = SW'(p_mb);
    bus.local_mode  = p_local[0];
    if (vld) begin
      lut  = (s == t) ? p_match : p_mis;
      diag = clampi((nl ? 0 : m_diag) + lut);
      e    = maxi(clampi((nl ? 0 : m_e) + p_mb), m_va);
      f    = maxi(vina, clampi(fin + p_mb));
      v    = maxi(maxi(e, f), p_local ? maxi(diag, 0) : diag);
      npos = nl ? 0 : ((m_pos == PMAX) ? PMAX : m_pos + 1);
      if (nl) begin
        m_best = v; m_bpos = 0;
      end else if (v > m_best) begin
        m_best = v; m_bpos = npos;
      end
      if (p_local != 0 && v == 0 && diag <= 0) m_dir = 0;
      else if (diag == v) m_dir = 1;
      else if (e == v)    m_dir = 2;
      else                m_dir = 3;
      m_diag = vin; m_e = e; m_v = v; m_va = clampi(v + p_ma); m_f = f;
      m_pos = npos; m_nl = nl; m_t = t; m_vo = 1;
    end else begin
      m_vo = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.valid_in = 1'b0;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++)
      step(1, i == 0, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40));
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", bus.valid_out); else passed++;
    checks++; if (bus.v_out !== '0) $display("FAIL reset_v_out got %0d want 0", bus.v_out); else passed++;
    checks++; if (bus.v_out_alpha !== '0) $display("FAIL reset_v_out_alpha got %0d want 0", bus.v_out_alpha); else passed++;
    checks++; if (bus.f_out !== '0) $display("FAIL reset_f_out got %0d want 0", bus.f_out); else passed++;
    checks++; if (bus.best_score !== '0 || bus.best_pos !== '0)
      $display("FAIL reset_best got %0d@%0d want 0@0", bus.best_score, bus.best_pos); else passed++;
    checks++; if (bus.t_out !== '0 || bus.new_line_out !== 1'b0)
      $display("FAIL reset_t_nl got t=%0d nl=%b want 0/0", bus.t_out, bus.new_line_out); else passed++;
`ifdef SW_PE_TRACEBACK_EN
    checks++; if (bus.tb_dir !== 2'b00) $display("FAIL reset_tb_dir got %b want 00", bus.tb_dir); else passed++;
`endif
    model_clear();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_first_cell();
    do_reset();
    step(1, 1, 1, 1, 0, -3, 0);
    checks++; if (bus.valid_out !== 1'b1) $display("FAIL first_valid got %b want 1", bus.valid_out); else passed++;
    checks++; if ($signed(bus.v_out) !== 2 || $signed(bus.v_out_alpha) !== -1 || $signed(bus.f_out) !== -1)
      $display("FAIL first_scores got v=%0d va=%0d f=%0d want 2/-1/-1", bus.v_out, bus.v_out_alpha, bus.f_out); else passed++;
    checks++; if ($signed(bus.best_score) !== 2 || bus.best_pos !== '0)
      $display("FAIL first_best got %0d@%0d want 2@0", bus.best_score, bus.best_pos); else passed++;
    checks++; if (bus.new_line_out !== 1'b1 || bus.t_out !== 2'd1)
      $display("FAIL first_fwd got nl=%b t=%0d want 1/1", bus.new_line_out, bus.t_out); else passed++;
  endtask

  task automatic test_stall();
    int cs[6], ct[6], cv[6], ca[6], cf[6];
    int ref_v, hv, hva, hf, hb;
    for (int i = 0; i < 6; i++) begin
      cs[i] = $urandom_range(0, 3); ct[i] = $urandom_range(0, 3);
      cv[i] = $urandom_range(0, 30); ca[i] = $urandom_range(0, 20) - 10;
      cf[i] = $urandom_range(0, 20) - 10;
    end
    do_reset();
    for (int i = 0; i < 6; i++) step(1, i == 0, cs[i], ct[i], cv[i], ca[i], cf[i]);
    ref_v = $signed(bus.v_out);
    checks++; if ($signed(bus.v_out) !== m_v) $display("FAIL stall_ref_v got %0d want %0d", bus.v_out, m_v); else passed++;
    do_reset();
    for (int i = 0; i < 2; i++) step(1, i == 0, cs[i], ct[i], cv[i], ca[i], cf[i]);
    hv = $signed(bus.v_out); hva = $signed(bus.v_out_alpha); hf = $signed(bus.f_out); hb = $signed(bus.best_score);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, $urandom_range(0, 3), $urandom_range(0, 3), 99, 99, 99);
      checks++; if (bus.valid_out !== 1'b0) $display("FAIL stall_valid got %b want 0", bus.valid_out); else passed++;
      checks++; if ($signed(bus.v_out) !== hv || $signed(bus.v_out_alpha) !== hva ||
                    $signed(bus.f_out) !== hf || $signed(bus.best_score) !== hb)
        $display("FAIL stall_hold got v=%0d va=%0d f=%0d b=%0d want %0d/%0d/%0d/%0d",
                 bus.v_out, bus.v_out_alpha, bus.f_out, bus.best_score, hv, hva, hf, hb);
      else passed++;
    end
    for (int i = 2; i < 6; i++) step(1, 0, cs[i], ct[i], cv[i], ca[i], cf[i]);
    checks++; if ($signed(bus.v_out) !== ref_v || bus.valid_out !== 1'b1)
      $display("FAIL stall_final got v=%0d vld=%b want %0d/1", bus.v_out, bus.valid_out, ref_v); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    step(1, 1, 0, 1, 126, -10, -10);
    step(1, 0, 2, 2, 0, -10, -10);
    checks++; if ($signed(bus.v_out) !== 127 || $signed(bus.v_out_alpha) !== 124)
      $display("FAIL sat_high got v=%0d va=%0d want 127/124", bus.v_out, bus.v_out_alpha); else passed++;
    do_reset();
    p_local = 0; p_mb = -128; p_mis = -128;
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 0, 1, -127, -128, -128);
      checks++; if ($signed(bus.v_out) !== m_v || $signed(bus.v_out_alpha) !== m_va)
        $display("FAIL sat_ramp got v=%0d va=%0d want %0d/%0d", bus.v_out, bus.v_out_alpha, m_v, m_va); else passed++;
    end
    p_match = 0;
    step(1, 0, 1, 1, -127, -128, -128);
    checks++; if ($signed(bus.v_out) !== -127 || $signed(bus.v_out_alpha) !== -128)
      $display("FAIL sat_low got v=%0d va=%0d want -127/-128", bus.v_out, bus.v_out_alpha); else passed++;
    set_defaults();
  endtask

  task automatic test_global();
    do_reset();
    p_local = 0;
    step(1, 1, 0, 1, 0, -5, -5);
    step(1, 1, 0, 1, 0, -5, -5);
    checks++; if ($signed(bus.v_out) !== -1) $display("FAIL global_noclamp got %0d want -1", bus.v_out); else passed++;
    do_reset();
    p_local = 1;
    step(1, 1, 0, 1, 0, -5, -5);
    step(1, 1, 0, 1, 0, -5, -5);
    checks++; if ($signed(bus.v_out) !== 0) $display("FAIL local_clamp got %0d want 0", bus.v_out); else passed++;
    set_defaults();
  endtask

  task automatic test_best();
    do_reset();
    step(1, 1, 1, 1, 3, -10, -10);
    step(1, 0, 1, 1, 3, -10, -10);
    step(1, 0, 1, 1, 4, -10, -10);
    checks++; if ($signed(bus.v_out) !== 5) $display("FAIL best_cell2_v got %0d want 5", bus.v_out); else passed++;
`ifdef SW_PE_TRACEBACK_EN
    checks++; if (bus.tb_dir !== 2'b01) $display("FAIL best_cell2_dir got %b want 01", bus.tb_dir); else passed++;
`endif
    step(1, 0, 1, 2, 0, -10, -10);
    checks++; if ($signed(bus.v_out) !== 3 || $signed(bus.best_score) !== 5 || bus.best_pos !== 4'd1)
      $display("FAIL best_line got v=%0d best=%0d@%0d want 3 5@1", bus.v_out, bus.best_score, bus.best_pos); else passed++;
    step(1, 1, 1, 2, 0, 1, -10);
    checks++; if ($signed(bus.best_score) !== 1 || bus.best_pos !== 4'd0)
      $display("FAIL best_newline got %0d@%0d want 1@0", bus.best_score, bus.best_pos); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        p_local = $urandom_range(0, 1);
        p_match = $urandom_range(0, 8);
        p_mis   = -int'($urandom_range(0, 8));
        p_ma    = -int'($urandom_range(0, 12));
        p_mb    = -int'($urandom_range(0, 4));
      end
      step($urandom_range(0, 3) != 0, (i == 0) || ($urandom_range(0, 15) == 0),
           $urandom_range(0, 3), $urandom_range(0, 3),
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128);
      checks++;
      if (bus.valid_out !== m_vo[0] || $signed(bus.v_out) !== m_v || $signed(bus.v_out_alpha) !== m_va ||
          $signed(bus.f_out) !== m_f || bus.t_out !== YW'(m_t) || bus.new_line_out !== m_nl[0])
        $display("FAIL rand_cell%0d got vld=%b v=%0d va=%0d f=%0d t=%0d nl=%b want %0d/%0d/%0d/%0d/%0d/%0d",
                 i, bus.valid_out, bus.v_out, bus.v_out_alpha, bus.f_out, bus.t_out, bus.new_line_out,
                 m_vo, m_v, m_va, m_f, m_t, m_nl);
      else passed++;
      checks++;
      if ($signed(bus.best_score) !== m_best || bus.best_pos !== PW'(m_bpos))
        $display("FAIL rand_best%0d got %0d@%0d want %0d@%0d", i, bus.best_score, bus.best_pos, m_best, m_bpos);
      else passed++;
`ifdef SW_PE_TRACEBACK_EN
      checks++;
      if (bus.tb_dir !== 2'(m_dir)) $display("FAIL rand_dir%0d got %b want %0d", i, bus.tb_dir, m_dir);
      else passed++;
`endif
    end
    set_defaults();
  endtask

  initial begin
    model_clear();
    set_defaults();
    bus.valid_in = 1'b0; bus.new_line_in = 1'b0; bus.s_sym = '0; bus.t_in = '0;
    bus.v_in = '0; bus.v_in_alpha = '0; bus.f_in = '0;
    bus.match = SW'(p_match); bus.mismatch = SW'(p_mis);
    bus.minus_alpha = SW'(p_ma); bus.minus_beta = SW'(p_mb); bus.local_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_first_cell();
    test_stall();
    test_saturation();
    test_global();
    test_best();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
